// File: rtl/clock_ctrl_pkg.sv
// Purpose: shared types and default widths for the CPU run-control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package clock_ctrl_pkg;

    localparam int BURST_W_DEF = 16;
    localparam int CNT_W_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        BURST  = 3'd3,
        HALTED = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/clock_ctrl_if.sv
// Purpose: request/status bundle between a run-control master and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; requests are level-sampled on each clock edge.
// Ports: run/halt/step/burst requests, burst_len, cpu_halt, clear_halt (master -> slave);
//        cpu_en, busy, done, halted, cycle_count (slave -> master).
interface clock_ctrl_if
    import clock_ctrl_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
);
    logic               run_req;
    logic               halt_req;
    logic               step_req;
    logic               burst_req;
    logic [BURST_W-1:0] burst_len;
    logic               cpu_halt;
    logic               clear_halt;
    logic               cpu_en;
    logic               busy;
    logic               done;
    logic               halted;
    logic [CNT_W-1:0]   cycle_count;

    modport master (
        output run_req, halt_req, step_req, burst_req, burst_len, cpu_halt, clear_halt,
        input  cpu_en, busy, done, halted, cycle_count
    );

    modport slave (
        input  run_req, halt_req, step_req, burst_req, burst_len, cpu_halt, clear_halt,
        output cpu_en, busy, done, halted, cycle_count
    );
endinterface

// File: rtl/clock_ctrl_sat_counter.sv
// Purpose: enable-gated up-counter that sticks at all-ones instead of wrapping.
// Latency: count reflects an enable one edge after it is sampled.
// Backpressure: none; en is honoured every cycle.
// Ports: clk, rst (async, active-high), en (count this edge), cnt (current value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/clock_ctrl.sv
// Purpose: turns run/halt/step/burst requests and core halts into a per-cycle cpu_en.
// Latency: request sampled at edge N changes state at N; cpu_en is high from N to N+1.
// Backpressure: none; requests not legal in the current state are dropped, not queued.
// Ports: clk, rst (async, active-high), bus (clock_ctrl_if.slave: requests in,
//        cpu_en/busy/done/halted/cycle_count out).
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    clock_ctrl_if.slave  bus
);
    ctrl_state_t        state_q, state_d;
    logic [BURST_W-1:0] rem_q, rem_d;
    logic               done_q, done_d;
    logic               cpu_en_q, cpu_en_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   cycle_cnt;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cpu_halt) begin
                    state_d = HALTED;
                end else if (bus.halt_req) begin
                    // halt_req outranks lower-priority starts arriving on the same edge
                    state_d = IDLE;
                end else if (bus.run_req) begin
                    state_d = RUN;
                end else if (bus.step_req) begin
                    state_d = STEP;
                end else if (bus.burst_req && (bus.burst_len != '0)) begin
                    state_d = BURST;
                    rem_d   = bus.burst_len;
                end
            end
            RUN: begin
                if (bus.cpu_halt) begin
                    state_d = HALTED;
                end else if (bus.halt_req) begin
                    state_d = IDLE;
                end
            end
            STEP: begin
                state_d = IDLE;
                if (!bus.cpu_halt && !bus.halt_req) begin
                    done_d = 1'b1;
                end else if (bus.cpu_halt) begin
                    state_d = HALTED;
                end
            end
            BURST: begin
                if (bus.cpu_halt) begin
                    state_d = HALTED;
                    rem_d   = '0;
                end else if (bus.halt_req) begin
                    state_d = IDLE;
                    rem_d   = '0;
                end else if (rem_q <= BURST_W'(1)) begin
                    // rem_q counts enabled cycles still owed including this one
                    state_d = IDLE;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    rem_d = rem_q - BURST_W'(1);
                end
            end
            HALTED: begin
                if (bus.clear_halt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase

        // Status outputs are registered copies of the next-state decode, so they
        // always match the state register and carry no input-to-output path.
        cpu_en_d = (state_d == RUN) || (state_d == STEP) || (state_d == BURST);
        halted_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rem_q    <= '0;
            done_q   <= 1'b0;
            cpu_en_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            done_q   <= done_d;
            cpu_en_q <= cpu_en_d;
            halted_q <= halted_d;
        end
    end

    // Counts edges at which the core was enabled, i.e. cycles it actually executed.
    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cpu_en_q),
        .cnt (cycle_cnt)
    );

    assign bus.cpu_en      = cpu_en_q;
    assign bus.busy        = cpu_en_q;
    assign bus.done        = done_q;
    assign bus.halted      = halted_q;
    assign bus.cycle_count = cycle_cnt;
endmodule
